// File: rtl/grad_accum_pkg.sv
// Shared definitions for the gradient accumulator: gate indices, FSM encoding
// and default fixed-point format.
package grad_accum_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 24;
    localparam int NUM_GATES = 4;

    localparam logic [1:0] GATE_A = 2'd0;
    localparam logic [1:0] GATE_I = 2'd1;
    localparam logic [1:0] GATE_F = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/grad_accum_sat_mult.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC
// (floor rounding), then saturation back into WIDTH bits.
module sat_mult #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] full;
    logic signed [PW-1:0] shifted;
    logic                 hi_ones;
    logic                 hi_zeros;

    assign full     = PW'(a) * PW'(b);
    assign shifted  = full >>> FRAC;

    // The result fits only if every bit above the WIDTH-bit sign is a copy of it
    assign hi_ones  = &shifted[PW-1:WIDTH-1];
    assign hi_zeros = ~|shifted[PW-1:WIDTH-1];

    always_comb begin
        p = shifted[WIDTH-1:0];
        if (!(hi_ones || hi_zeros)) begin
            p = shifted[PW-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/grad_accum.sv
// Per-gate gradient accumulator: sums saturated dgate*x products into four
// accumulators and drains them gate by gate after the last sample of a sequence.
module grad_accum
    import grad_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [1:0]       i_gate,
    input  logic [WIDTH-1:0] i_dgate,
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_first,
    input  logic             i_last,
    output logic             o_valid,
    output logic [1:0]       o_gate,
    output logic [WIDTH-1:0] o_grad
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic             flush_cnt;
    logic             xfer;
    logic             drain_done;
    logic [WIDTH-1:0] prod;

    logic             p_valid;
    logic [1:0]       p_gate;
    logic             p_first;
    logic [WIDTH-1:0] p_prod;
    logic [WIDTH-1:0] acc [NUM_GATES];

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return s[WIDTH-1:0];
    endfunction

    assign xfer       = i_valid && i_ready;
    assign drain_done = (state == ST_DRAIN) && (o_gate == GATE_O);
    assign o_grad     = o_valid ? acc[o_gate] : '0;

    sat_mult #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) u_mult (
        .a(i_dgate),
        .b(i_x),
        .p(prod)
    );

    // Product stage then accumulate stage; each sample reads the accumulator
    // value written by its predecessor, so same-gate back-to-back needs no stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_valid <= 1'b0;
            p_gate  <= GATE_A;
            p_first <= 1'b0;
            p_prod  <= '0;
            for (int g = 0; g < NUM_GATES; g++) begin
                acc[g] <= '0;
            end
        end else begin
            p_valid <= xfer;
            if (xfer) begin
                p_gate  <= i_gate;
                p_first <= i_first;
                p_prod  <= prod;
            end
            if (drain_done) begin
                for (int g = 0; g < NUM_GATES; g++) begin
                    acc[g] <= '0;
                end
            end else if (p_valid) begin
                acc[p_gate] <= p_first ? p_prod : sat_add(acc[p_gate], p_prod);
            end
        end
    end

    // Handshake and drain sequencing; ready is held low from the last transfer
    // through FLUSH and DRAIN so the outputs always reflect a settled sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            flush_cnt <= 1'b0;
            i_ready   <= 1'b0;
            o_valid   <= 1'b0;
            o_gate    <= GATE_A;
        end else begin
            case (state)
                ST_IDLE, ST_ACC: begin
                    i_ready <= 1'b1;
                    if (xfer) begin
                        if (i_last) begin
                            state     <= ST_FLUSH;
                            i_ready   <= 1'b0;
                            flush_cnt <= 1'b0;
                        end else begin
                            state <= ST_ACC;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state   <= ST_DRAIN;
                        o_valid <= 1'b1;
                        o_gate  <= GATE_A;
                    end
                end
                ST_DRAIN: begin
                    if (o_gate == GATE_O) begin
                        state   <= ST_IDLE;
                        o_valid <= 1'b0;
                        o_gate  <= GATE_A;
                        i_ready <= 1'b1;
                    end else begin
                        o_gate <= o_gate + 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grad_accum.sv
// Randomized scoreboard bench for grad_accum: a fixed-point reference model
// predicts each drain, and a negedge monitor compares what the DUT emits.
module tb_grad_accum;

    localparam int     WIDTH = 32;
    localparam int     FRAC  = 24;
    localparam longint MAXV  = 64'sd2147483647;
    localparam longint MINV  = -64'sd2147483648;

    typedef struct {
        logic [1:0]  gate;
        logic [31:0] dgate;
        logic [31:0] x;
        logic        first;
        logic        last;
    } sample_t;

    typedef struct {
        logic [1:0]  gate;
        logic [31:0] grad;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [1:0]       i_gate = '0;
    logic [WIDTH-1:0] i_dgate = '0;
    logic [WIDTH-1:0] i_x = '0;
    logic             i_first = 1'b0;
    logic             i_last = 1'b0;
    logic             o_valid;
    logic [1:0]       o_gate;
    logic [WIDTH-1:0] o_grad;

    exp_t    exp_q[$];
    sample_t seq[$];
    longint  ref_acc[4];
    int      checks = 0;
    int      errors = 0;

    grad_accum #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_gate (i_gate),
        .i_dgate(i_dgate),
        .i_x    (i_x),
        .i_first(i_first),
        .i_last (i_last),
        .o_valid(o_valid),
        .o_gate (o_gate),
        .o_grad (o_grad)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic longint clampW(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Real-number view: (d/2^FRAC)*(x/2^FRAC) rescaled by 2^FRAC, floored, clamped
    function automatic longint refMult(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return clampW((sa * sb) >>> FRAC);
    endfunction

    function automatic sample_t mk(input logic [1:0] g, input logic [31:0] d,
                                   input logic [31:0] x, input logic f, input logic l);
        sample_t s;
        s.gate = g; s.dgate = d; s.x = x; s.first = f; s.last = l;
        return s;
    endfunction

    function automatic logic [31:0] randVal();
        logic signed [31:0] v;
        v = $urandom;
        return v >>> $urandom_range(0, 10);
    endfunction

    task automatic modelSample(input sample_t s);
        exp_t   e;
        longint p;
        p = refMult(s.dgate, s.x);
        ref_acc[s.gate] = s.first ? p : clampW(ref_acc[s.gate] + p);
        if (s.last) begin
            for (int g = 0; g < 4; g++) begin
                e.gate = 2'(g);
                e.grad = 32'(ref_acc[g]);
                exp_q.push_back(e);
                ref_acc[g] = 0;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the sample transferred
    task automatic applyStimulus(input sample_t s, input int gap);
        int waited;
        i_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        i_gate = s.gate; i_dgate = s.dgate; i_x = s.x;
        i_first = s.first; i_last = s.last; i_valid = 1'b1;
        waited = 0;
        while (i_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (i_ready !== 1'b1) checkOutput("ready_wait_timeout", {63'd0, i_ready}, 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        modelSample(s);
    endtask

    task automatic finishSeq(input bit hold);
        int cnt;
        if (hold) begin
            i_valid = 1'b1; i_gate = 2'($urandom); i_dgate = $urandom; i_x = $urandom;
            i_first = 1'b1; i_last = 1'b1;
        end
        cnt = 0;
        while (i_ready !== 1'b1 && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        i_valid = 1'b0;
        checkOutput("ready_low_cycles", 64'(cnt), 64'd6);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("drain_complete", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic runSeq(input bit hold, input bit gaps);
        foreach (seq[i]) applyStimulus(seq[i], gaps ? int'($urandom_range(0, 2)) : 0);
        finishSeq(hold);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got gate %0d grad 0x%0h, expected none",
                         o_gate, o_grad);
            end else begin
                e = exp_q.pop_front();
                checkOutput("drain_gate", 64'(o_gate), 64'(e.gate));
                checkOutput($sformatf("drain_grad_g%0d", e.gate), 64'(o_grad), 64'(e.grad));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int w;
        int len;
        for (int g = 0; g < 4; g++) ref_acc[g] = 0;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", {63'd0, i_ready}, 64'd0);
        checkOutput("reset_valid", {63'd0, o_valid}, 64'd0);
        checkOutput("reset_gate", 64'(o_gate), 64'd0);
        checkOutput("reset_grad", 64'(o_grad), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", {63'd0, i_ready}, 64'd1);

        $display("[TB] single sample");
        seq.delete();
        seq.push_back(mk(2'd1, 32'h00800000, 32'h02000000, 1'b1, 1'b1));
        runSeq(1'b0, 1'b0);

        $display("[TB] back-to-back accumulate");
        seq.delete();
        seq.push_back(mk(2'd2, 32'h01000000, 32'h01000000, 1'b1, 1'b0));
        seq.push_back(mk(2'd2, 32'h01000000, 32'h01000000, 1'b0, 1'b0));
        seq.push_back(mk(2'd2, 32'h01000000, 32'h01000000, 1'b0, 1'b1));
        runSeq(1'b0, 1'b0);

        $display("[TB] positive and negative saturation");
        seq.delete();
        seq.push_back(mk(2'd0, 32'h7F000000, 32'h01000000, 1'b1, 1'b0));
        seq.push_back(mk(2'd0, 32'h7F000000, 32'h01000000, 1'b0, 1'b0));
        seq.push_back(mk(2'd0, 32'h7F000000, 32'h01000000, 1'b0, 1'b1));
        runSeq(1'b0, 1'b0);
        seq.delete();
        seq.push_back(mk(2'd0, 32'h81000000, 32'h01000000, 1'b1, 1'b0));
        seq.push_back(mk(2'd0, 32'h81000000, 32'h01000000, 1'b0, 1'b0));
        seq.push_back(mk(2'd0, 32'h81000000, 32'h01000000, 1'b0, 1'b1));
        runSeq(1'b0, 1'b0);

        $display("[TB] valid held through flush and drain");
        seq.delete();
        seq.push_back(mk(2'd1, 32'h00800000, 32'h02000000, 1'b1, 1'b0));
        seq.push_back(mk(2'd3, 32'hFF000000, 32'h00400000, 1'b1, 1'b1));
        runSeq(1'b1, 1'b0);

        $display("[TB] re-first on gate 3");
        seq.delete();
        seq.push_back(mk(2'd3, 32'h01000000, 32'h02000000, 1'b1, 1'b0));
        seq.push_back(mk(2'd3, 32'h00400000, 32'h01000000, 1'b1, 1'b1));
        runSeq(1'b0, 1'b0);

        $display("[TB] reset during drain");
        applyStimulus(mk(2'd1, 32'h00800000, 32'h02000000, 1'b1, 1'b1), 0);
        w = 0;
        while (exp_q.size() != 2 && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        checkOutput("reached_mid_drain", 64'(exp_q.size()), 64'd2);
        rst = 1'b0;
        #1;
        checkOutput("rst_drops_valid", {63'd0, o_valid}, 64'd0);
        checkOutput("rst_drops_grad", 64'(o_grad), 64'd0);
        exp_q.delete();
        for (int g = 0; g < 4; g++) ref_acc[g] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_midreset", {63'd0, i_ready}, 64'd1);
        seq.delete();
        seq.push_back(mk(2'd3, 32'h01000000, 32'h01000000, 1'b1, 1'b1));
        runSeq(1'b0, 1'b0);

        $display("[TB] randomized sequences");
        for (int n = 0; n < 30; n++) begin
            seq.delete();
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                seq.push_back(mk(2'($urandom_range(0, 3)), randVal(), randVal(),
                                 ($urandom_range(0, 3) == 0), (k == len - 1)));
            end
            runSeq(($urandom_range(0, 2) == 0), 1'b1);
        end

        repeat (4) @(posedge clk);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
